// File: rtl/spi_pkg.sv
// spi_pkg -- shared SPI constants, mode settings and controller state encoding.
// Rev 1.0
`default_nettype none

package spi_pkg;

   localparam int SPI_DATA_W = 8;
   localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);
   localparam logic [SPI_CNT_W-1:0] SPI_LAST_BIT = SPI_CNT_W'(SPI_DATA_W - 1);

   // Mode 0, MSB first; the master driver uses the same constants.
   localparam logic SPI_CPOL      = 1'b0;
   localparam logic SPI_CPHA      = 1'b0;
   localparam logic SPI_MSB_FIRST = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_slave_driver_if.sv
// spi_slave_driver_if -- system-side handshake and SPI pin bundle of the slave.
// Rev 1.0
`default_nettype none

interface spi_slave_driver_if;
   import spi_pkg::*;

   logic                  load_i;
   logic [SPI_DATA_W-1:0] data_in_bi;
   logic [SPI_DATA_W-1:0] data_out_bo;
   logic                  valid_o;
   logic                  busy_o;
   logic                  spi_sclk_i;
   logic                  spi_cs_i;
   logic                  spi_mosi_i;
   logic                  spi_miso_o;

   modport slave (
      input  load_i, data_in_bi, spi_sclk_i, spi_cs_i, spi_mosi_i,
      output data_out_bo, valid_o, busy_o, spi_miso_o
   );

   modport master (
      output load_i, data_in_bi, spi_sclk_i, spi_cs_i, spi_mosi_i,
      input  data_out_bo, valid_o, busy_o, spi_miso_o
   );

endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// spi_sync_edge -- multi-flop synchroniser with level and rise/fall detection.
// Rev 1.0
`default_nettype none

module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d_i};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign level_o = chain[SYNC_STAGES-1];
   assign rise_o  = chain[SYNC_STAGES-1] & ~prev;
   assign fall_o  = ~chain[SYNC_STAGES-1] & prev;

endmodule

`default_nettype wire

// File: rtl/spi_slave_driver.sv
// spi_slave_driver -- mode-0 SPI target, pins oversampled into clk_i, multi-byte bursts.
// Rev 1.0
`default_nettype none

module spi_slave_driver
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   spi_slave_driver_if.slave  bus
);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic unused_levels;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .d_i     (bus.spi_sclk_i),
      .level_o (sclk_level),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .d_i     (bus.spi_cs_i),
      .level_o (cs_level),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   assign unused_levels = sclk_level ^ cs_level;

   // Same depth as the SCLK chain so MOSI is sampled at the bit it belongs to.
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic                   mosi_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) mosi_chain <= '0;
      else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.spi_mosi_i};
   end

   assign mosi_sync = mosi_chain[SYNC_STAGES-1];

   spi_state_t            state, state_n;
   logic [SPI_DATA_W-1:0] tx_buf, tx_buf_n;
   logic [SPI_DATA_W-1:0] tx_sr, tx_sr_n;
   logic [SPI_DATA_W-1:0] rx_sr, rx_sr_n;
   logic [SPI_DATA_W-1:0] data_out, data_out_n;
   logic [SPI_CNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic                  valid, valid_n;
   logic                  miso, miso_n;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         tx_buf   <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         data_out <= '0;
         bit_cnt  <= '0;
         valid    <= 1'b0;
         miso     <= 1'b0;
      end else begin
         state    <= state_n;
         tx_buf   <= tx_buf_n;
         tx_sr    <= tx_sr_n;
         rx_sr    <= rx_sr_n;
         data_out <= data_out_n;
         bit_cnt  <= bit_cnt_n;
         valid    <= valid_n;
         miso     <= miso_n;
      end
   end

   always_comb begin
      state_n    = state;
      tx_buf_n   = bus.load_i ? bus.data_in_bi : tx_buf;
      tx_sr_n    = tx_sr;
      rx_sr_n    = rx_sr;
      data_out_n = data_out;
      bit_cnt_n  = bit_cnt;
      valid_n    = 1'b0;
      miso_n     = miso;

      // tx_buf_n doubles as the bypass path for a load coinciding with a reload.
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_n   = SHIFT;
               tx_sr_n   = tx_buf_n;
               miso_n    = tx_buf_n[SPI_DATA_W-1];
               bit_cnt_n = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_n   = IDLE;
               miso_n    = 1'b0;
               bit_cnt_n = '0;
            end else if (sclk_rise) begin
               rx_sr_n = {rx_sr[SPI_DATA_W-2:0], mosi_sync};
               if (bit_cnt == SPI_LAST_BIT) begin
                  data_out_n = {rx_sr[SPI_DATA_W-2:0], mosi_sync};
                  valid_n    = 1'b1;
                  bit_cnt_n  = '0;
                  tx_sr_n    = tx_buf_n;
               end else begin
                  bit_cnt_n = bit_cnt + SPI_CNT_W'(1);
               end
            end else if (sclk_fall) begin
               // bit_cnt of 0 here means a byte boundary: show the fresh MSB unshifted.
               if (bit_cnt == '0) begin
                  miso_n = tx_sr[SPI_DATA_W-1];
               end else begin
                  tx_sr_n = {tx_sr[SPI_DATA_W-2:0], 1'b0};
                  miso_n  = tx_sr[SPI_DATA_W-2];
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.data_out_bo = data_out;
   assign bus.valid_o     = valid;
   assign bus.busy_o      = (state == SHIFT);
   assign bus.spi_miso_o  = miso;

endmodule

`default_nettype wire
